// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

  typedef enum {IDLE, START, DATA, PAR, STOP} rx_state_e;

  localparam int BAUD_19200_50M = 2604;

  // True when data plus parity bit satisfy the selected parity rule.
  function automatic logic parity_ok(input parity_e mode, input logic [8:0] data, input logic par_bit);
    case (mode)
      PAR_ODD:  return ^{data, par_bit};
      PAR_EVEN: return ~^{data, par_bit};
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Pin/command-processor side signals of the UART receiver.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          RX;
  logic                          rd_en;
  logic                          clr_err;
  logic [DATA_BITS-1:0]          rx_data;
  logic                          rdy;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          frame_err;
  logic                          parity_err;
  logic                          overrun;

  modport slave (
    input  RX, rd_en, clr_err,
    output rx_data, rdy, count, frame_err, parity_err, overrun
  );

  modport master (
    output RX, rd_en, clr_err,
    input  rx_data, rdy, count, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with show-ahead read; push+pop in one cycle is honoured even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot being written (wr_ptr == rd_ptr).
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchroniser, mid-bit sampling FSM, parity/stop checks, sticky errors, receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = BAUD_19200_50M,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);
  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam parity_e       PMODE     = (PARITY == 1) ? PAR_ODD :
                                        (PARITY == 2) ? PAR_EVEN : PAR_NONE;

  logic                 rx_meta, rx_sync, rx_prev;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 tick, fall, done;
  logic                 par_good, push, frame_set, par_set, ovr_set;
  logic                 fifo_full, fifo_empty;
  logic                 frame_err_q, parity_err_q, overrun_q;

  assign tick = (baud_q == '0);
  assign fall = rx_prev & ~rx_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_bad_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta      <= bus.RX;
      rx_sync      <= rx_meta;
      rx_prev      <= rx_sync;
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      stop_bad_q   <= stop_bad_d;
      frame_err_q  <= frame_set | (frame_err_q  & ~bus.clr_err);
      parity_err_q <= par_set   | (parity_err_q & ~bus.clr_err);
      overrun_q    <= ovr_set   | (overrun_q    & ~bus.clr_err);
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = tick ? baud_q : baud_q - 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_bad_d = stop_bad_q;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          baud_d     = HALF_LOAD;
          bit_d      = '0;
          stop_bad_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (rx_sync) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            baud_d  = FULL_LOAD;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          baud_d  = FULL_LOAD;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PMODE == PAR_NONE) ? STOP : PAR;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          par_d   = rx_sync;
          baud_d  = FULL_LOAD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          stop_bad_d = stop_bad_q | ~rx_sync;
          baud_d     = FULL_LOAD;
          // Return to IDLE at the last stop sample so a start edge mid-stop is caught.
          if (bit_q == LAST_STOP) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stop-bit failure outranks parity; only clean words reach the FIFO.
  assign par_good  = parity_ok(PMODE, 9'(shift_q), par_q);
  assign frame_set = done & stop_bad_d;
  assign par_set   = done & ~stop_bad_d & ~par_good;
  assign push      = done & ~stop_bad_d & par_good;
  assign ovr_set   = push & fifo_full & ~bus.rd_en;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (shift_q),
    .pop     (bus.rd_en),
    .rd_data (bus.rx_data),
    .count   (bus.count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.rdy        = ~fifo_empty;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: default 8N1 receiver (A) and a 7-bit even-parity 2-stop receiver (B).
module tb_uart_rx_fifo;
  localparam int BD = 16;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) a_if ();
  uart_rx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) b_if ();

  uart_rx_fifo #(
    .DATA_BITS (8), .BAUD_DIV (BD), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) dut_a (.clk(clk), .rst(rst), .bus(a_if));

  uart_rx_fifo #(
    .DATA_BITS (7), .BAUD_DIV (BD), .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (4)
  ) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_rx(input int unsigned which, input logic v);
    if (which == 0) a_if.RX = v;
    else            b_if.RX = v;
  endtask

  task automatic drive_bit(input int unsigned which, input logic v);
    set_rx(which, v);
    repeat (BD) @(posedge clk);
    #1;
  endtask

  // pforce < 0 computes the correct parity bit; otherwise pforce[0] is sent.
  task automatic send(input int unsigned which, input logic [8:0] data, input int unsigned nbits,
                      input int unsigned pmode, input int pforce, input int unsigned nstop,
                      input logic [1:0] stops);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) p = p ^ data[i];
    if (pmode == 1) p = ~p;
    if (pforce >= 0) p = pforce[0];
    drive_bit(which, 1'b0);
    for (int unsigned i = 0; i < nbits; i++) drive_bit(which, data[i]);
    if (pmode != 0) drive_bit(which, p);
    for (int unsigned i = 0; i < nstop; i++) drive_bit(which, stops[i]);
    set_rx(which, 1'b1);
  endtask

  task automatic pop(input int unsigned which);
    if (which == 0) a_if.rd_en = 1'b1; else b_if.rd_en = 1'b1;
    @(posedge clk); #1;
    a_if.rd_en = 1'b0;
    b_if.rd_en = 1'b0;
  endtask

  task automatic clr(input int unsigned which);
    if (which == 0) a_if.clr_err = 1'b1; else b_if.clr_err = 1'b1;
    @(posedge clk); #1;
    a_if.clr_err = 1'b0;
    b_if.clr_err = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (a_if.rdy !== 1'b0) $display("FAIL rst_a_rdy got %b want 0", a_if.rdy); else n_pass++;
    n_checks++; if (a_if.count !== 3'd0) $display("FAIL rst_a_count got %0d want 0", a_if.count); else n_pass++;
    n_checks++; if (a_if.rx_data !== 8'h00) $display("FAIL rst_a_data got %h want 00", a_if.rx_data); else n_pass++;
    n_checks++; if ({a_if.frame_err, a_if.parity_err, a_if.overrun} !== 3'b000)
      $display("FAIL rst_a_flags got %b want 000", {a_if.frame_err, a_if.parity_err, a_if.overrun}); else n_pass++;
    n_checks++; if (b_if.rdy !== 1'b0) $display("FAIL rst_b_rdy got %b want 0", b_if.rdy); else n_pass++;
    n_checks++; if (b_if.count !== 3'd0) $display("FAIL rst_b_count got %0d want 0", b_if.count); else n_pass++;
    n_checks++; if ({b_if.frame_err, b_if.parity_err, b_if.overrun} !== 3'b000)
      $display("FAIL rst_b_flags got %b want 000", {b_if.frame_err, b_if.parity_err, b_if.overrun}); else n_pass++;
  endtask

  // rdy expected 3 sync/edge cycles + BD/2 + 9*BD = 155 edges after the start bit is driven.
  task automatic test_single;
    int n;
    n = 0;
    fork
      send(0, 9'h075, 8, 0, -1, 1, 2'b11);
      begin
        while (n < 400) begin
          @(posedge clk); #1;
          n++;
          if (a_if.rdy === 1'b1) break;
        end
      end
    join
    n_checks++; if (n != 155) $display("FAIL single_latency got %0d want 155", n); else n_pass++;
    n_checks++; if (a_if.rx_data !== 8'h75) $display("FAIL single_data got %h want 75", a_if.rx_data); else n_pass++;
    n_checks++; if (a_if.count !== 3'd1) $display("FAIL single_count got %0d want 1", a_if.count); else n_pass++;
    n_checks++; if ({a_if.frame_err, a_if.parity_err, a_if.overrun} !== 3'b000)
      $display("FAIL single_flags got %b want 000", {a_if.frame_err, a_if.parity_err, a_if.overrun}); else n_pass++;
    pop(0);
    n_checks++; if (a_if.rdy !== 1'b0) $display("FAIL single_pop_rdy got %b want 0", a_if.rdy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [5];
    bytes = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h3C};
    for (int i = 0; i < 5; i++) send(0, {1'b0, bytes[i]}, 8, 0, -1, 1, 2'b11);
    n_checks++; if (a_if.count !== 3'd4) $display("FAIL b2b_count got %0d want 4", a_if.count); else n_pass++;
    n_checks++; if (a_if.overrun !== 1'b1) $display("FAIL b2b_overrun got %b want 1", a_if.overrun); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (a_if.rx_data !== bytes[i])
        $display("FAIL b2b_pop%0d got %h want %h", i, a_if.rx_data, bytes[i]); else n_pass++;
      pop(0);
    end
    n_checks++; if (a_if.rdy !== 1'b0) $display("FAIL b2b_empty_rdy got %b want 0", a_if.rdy); else n_pass++;
    pop(0);
    n_checks++; if (a_if.count !== 3'd0) $display("FAIL b2b_pop_empty got %0d want 0", a_if.count); else n_pass++;
    clr(0);
    n_checks++; if (a_if.overrun !== 1'b0) $display("FAIL b2b_clr got %b want 0", a_if.overrun); else n_pass++;
  endtask

  task automatic test_full_pop_push;
    logic [7:0] exp [4];
    for (int i = 1; i <= 4; i++) send(0, 9'(i * 8'h11), 8, 0, -1, 1, 2'b11);
    n_checks++; if (a_if.count !== 3'd4) $display("FAIL fpp_fill got %0d want 4", a_if.count); else n_pass++;
    fork
      send(0, 9'h055, 8, 0, -1, 1, 2'b11);
      begin
        repeat (154) @(posedge clk);
        #1 a_if.rd_en = 1'b1;
        @(posedge clk);
        #1 a_if.rd_en = 1'b0;
      end
    join
    n_checks++; if (a_if.count !== 3'd4) $display("FAIL fpp_count got %0d want 4", a_if.count); else n_pass++;
    n_checks++; if (a_if.overrun !== 1'b0) $display("FAIL fpp_overrun got %b want 0", a_if.overrun); else n_pass++;
    exp = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (a_if.rx_data !== exp[i])
        $display("FAIL fpp_pop%0d got %h want %h", i, a_if.rx_data, exp[i]); else n_pass++;
      pop(0);
    end
    n_checks++; if (a_if.rdy !== 1'b0) $display("FAIL fpp_empty got %b want 0", a_if.rdy); else n_pass++;
  endtask

  task automatic test_parity;
    send(1, 9'h003, 7, 2, 1, 2, 2'b11);
    n_checks++; if (b_if.parity_err !== 1'b1) $display("FAIL par_err got %b want 1", b_if.parity_err); else n_pass++;
    n_checks++; if (b_if.count !== 3'd0) $display("FAIL par_count got %0d want 0", b_if.count); else n_pass++;
    clr(1);
    n_checks++; if (b_if.parity_err !== 1'b0) $display("FAIL par_clr got %b want 0", b_if.parity_err); else n_pass++;
    send(1, 9'h055, 7, 2, -1, 2, 2'b11);
    n_checks++; if (b_if.rx_data !== 7'h55) $display("FAIL par_good_data got %h want 55", b_if.rx_data); else n_pass++;
    n_checks++; if (b_if.parity_err !== 1'b0) $display("FAIL par_good_flag got %b want 0", b_if.parity_err); else n_pass++;
    pop(1);
    // clr_err lands on the same edge as the parity error (last stop sample at edge 171).
    fork
      send(1, 9'h003, 7, 2, 1, 2, 2'b11);
      begin
        repeat (170) @(posedge clk);
        #1 b_if.clr_err = 1'b1;
        @(posedge clk);
        #1 b_if.clr_err = 1'b0;
      end
    join
    n_checks++; if (b_if.parity_err !== 1'b1) $display("FAIL par_setwins got %b want 1", b_if.parity_err); else n_pass++;
    clr(1);
    send(1, 9'h02A, 7, 2, -1, 2, 2'b01);
    n_checks++; if (b_if.frame_err !== 1'b1) $display("FAIL stop2_frame got %b want 1", b_if.frame_err); else n_pass++;
    n_checks++; if (b_if.count !== 3'd0) $display("FAIL stop2_count got %0d want 0", b_if.count); else n_pass++;
    clr(1);
    send(1, 9'h003, 7, 2, 1, 2, 2'b01);
    n_checks++; if ({b_if.frame_err, b_if.parity_err} !== 2'b10)
      $display("FAIL prio_flags got %b want 10", {b_if.frame_err, b_if.parity_err}); else n_pass++;
    clr(1);
  endtask

  task automatic test_frame_err;
    send(0, 9'h000, 8, 0, -1, 1, 2'b00);
    n_checks++; if (a_if.frame_err !== 1'b1) $display("FAIL ferr_flag got %b want 1", a_if.frame_err); else n_pass++;
    n_checks++; if (a_if.count !== 3'd0) $display("FAIL ferr_count got %0d want 0", a_if.count); else n_pass++;
    repeat (BD) @(posedge clk);
    #1;
    send(0, 9'h041, 8, 0, -1, 1, 2'b11);
    n_checks++; if (a_if.rx_data !== 8'h41) $display("FAIL ferr_next_data got %h want 41", a_if.rx_data); else n_pass++;
    n_checks++; if (a_if.count !== 3'd1) $display("FAIL ferr_next_count got %0d want 1", a_if.count); else n_pass++;
    n_checks++; if (a_if.frame_err !== 1'b1) $display("FAIL ferr_sticky got %b want 1", a_if.frame_err); else n_pass++;
  endtask

  task automatic test_glitch_and_reset;
    a_if.RX = 1'b0;
    repeat (BD / 4) @(posedge clk);
    #1 a_if.RX = 1'b1;
    repeat (2 * BD) @(posedge clk);
    #1;
    n_checks++; if (a_if.count !== 3'd1) $display("FAIL glitch_count got %0d want 1", a_if.count); else n_pass++;
    n_checks++; if ({a_if.frame_err, a_if.parity_err, a_if.overrun} !== 3'b100)
      $display("FAIL glitch_flags got %b want 100", {a_if.frame_err, a_if.parity_err, a_if.overrun}); else n_pass++;
    send(0, 9'h03C, 8, 0, -1, 1, 2'b11);
    n_checks++; if (a_if.count !== 3'd2) $display("FAIL glitch_next_count got %0d want 2", a_if.count); else n_pass++;
    pop(0);
    n_checks++; if (a_if.rx_data !== 8'h3C) $display("FAIL glitch_next_data got %h want 3C", a_if.rx_data); else n_pass++;
    // Abandon a frame part-way through the data bits.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rst = 1'b1;
    a_if.RX = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (a_if.rdy !== 1'b0) $display("FAIL mid_rst_rdy got %b want 0", a_if.rdy); else n_pass++;
    n_checks++; if (a_if.count !== 3'd0) $display("FAIL mid_rst_count got %0d want 0", a_if.count); else n_pass++;
    n_checks++; if (a_if.rx_data !== 8'h00) $display("FAIL mid_rst_data got %h want 00", a_if.rx_data); else n_pass++;
    n_checks++; if ({a_if.frame_err, a_if.parity_err, a_if.overrun} !== 3'b000)
      $display("FAIL mid_rst_flags got %b want 000", {a_if.frame_err, a_if.parity_err, a_if.overrun}); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4 * BD) @(posedge clk);
    #1;
    n_checks++; if (a_if.count !== 3'd0) $display("FAIL post_rst_idle got %0d want 0", a_if.count); else n_pass++;
    send(0, 9'h096, 8, 0, -1, 1, 2'b11);
    n_checks++; if (a_if.rx_data !== 8'h96) $display("FAIL post_rst_data got %h want 96", a_if.rx_data); else n_pass++;
    n_checks++; if (a_if.count !== 3'd1) $display("FAIL post_rst_count got %0d want 1", a_if.count); else n_pass++;
    n_checks++; if (a_if.frame_err !== 1'b0) $display("FAIL post_rst_ferr got %b want 0", a_if.frame_err); else n_pass++;
  endtask

  initial begin
    rst          = 1'b1;
    a_if.RX      = 1'b1;
    a_if.rd_en   = 1'b0;
    a_if.clr_err = 1'b0;
    b_if.RX      = 1'b1;
    b_if.rd_en   = 1'b0;
    b_if.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    test_single;
    test_back_to_back;
    test_full_pop_push;
    test_parity;
    test_frame_err;
    test_glitch_and_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
